// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state encoding and constants for the fetch sequencer
package fetch_sequencer_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DISCARD = 2'd2} state_t;
   localparam int WORD_BYTES = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction buffer with push/pop/flush and occupancy count
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q;
   logic do_push, do_pop;
   assign full_o  = count_q == CW'(DEPTH);
   assign empty_o = count_q == '0;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_q];
   assign count_o = count_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (do_pop) rd_q <= rd_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues one outstanding fetch at a time and buffers
// returned words for decode; branches flush the buffer and drop in-flight responses.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    FIFO_DEPTH = 2,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  o_Mem_Req,
   output logic [DATA_WIDTH-1:0] o_Mem_Address,
   input  logic                  i_Mem_Ready,
   input  logic [DATA_WIDTH-1:0] i_Mem_Instruction,
   input  logic                  i_Stall,
   input  logic                  i_Branch_Taken,
   input  logic [DATA_WIDTH-1:0] i_Branch_Address,
   output logic                  o_Valid,
   output logic [DATA_WIDTH-1:0] o_Instruction,
   output logic [DATA_WIDTH-1:0] o_PC
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_t state_q;
   logic req_q;
   logic [DATA_WIDTH-1:0] pc_q, target;
   logic [2*DATA_WIDTH-1:0] head;
   logic [CW-1:0] count;
   logic [CW:0] level;
   logic full, empty, push, pop, room;
   always_comb begin
      target = i_Branch_Address & ~DATA_WIDTH'(3);
      pop    = !empty && !i_Stall && !i_Branch_Taken;
      push   = state_q == FETCH && i_Mem_Ready && !i_Branch_Taken;
      level  = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
      // a push can never reach a full buffer, so full only frees up through a pop
      room   = full ? pop : level < (CW+1)'(FIFO_DEPTH);
   end
   fetch_fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push_i(push), .pop_i(pop), .flush_i(i_Branch_Taken),
      .data_i({i_Mem_Instruction, pc_q}), .data_o(head), .count_o(count),
      .full_o(full), .empty_o(empty)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         pc_q    <= RESET_PC;
      end else if (i_Branch_Taken) begin
         pc_q    <= target;
         state_q <= (state_q != IDLE && !i_Mem_Ready) ? DISCARD : FETCH;
         req_q   <= !(state_q != IDLE && !i_Mem_Ready);
      end else if (state_q == IDLE) begin
         state_q <= room ? FETCH : IDLE;
         req_q   <= room;
      end else if (i_Mem_Ready) begin
         pc_q    <= state_q == FETCH ? pc_q + DATA_WIDTH'(WORD_BYTES) : pc_q;
         state_q <= (state_q == DISCARD || room) ? FETCH : IDLE;
         req_q   <= state_q == DISCARD || room;
      end
   assign o_Mem_Req     = req_q;
   assign o_Mem_Address = pc_q;
   assign o_Valid       = !empty;
   assign o_Instruction = head[2*DATA_WIDTH-1:DATA_WIDTH];
   assign o_PC          = head[DATA_WIDTH-1:0];
endmodule
